// File: rtl/dual_inst_queue.sv
// dual_inst_queue: in-order instruction buffer between fetch and decode/issue.
// Up to two entries enter per cycle at the tail, and up to two leave per cycle
// from the head. The two oldest entries are presented as the inst1/inst2 pair.
// A jump/mispredict flush empties the queue on the next edge.
module dual_inst_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     jump_flag_i,
  input  logic                     push1_valid_i,
  input  logic [ADDR_W-1:0]        push1_addr_i,
  input  logic [DATA_W-1:0]        push1_inst_i,
  input  logic                     push1_is_pred_branch_i,
  input  logic                     push2_valid_i,
  input  logic [ADDR_W-1:0]        push2_addr_i,
  input  logic [DATA_W-1:0]        push2_inst_i,
  input  logic                     push2_is_pred_branch_i,
  output logic                     fetch_ready_o,
  output logic                     inst1_valid_o,
  output logic [ADDR_W-1:0]        inst1_addr_o,
  output logic [DATA_W-1:0]        inst1_o,
  output logic                     inst1_is_pred_branch_o,
  output logic                     inst2_valid_o,
  output logic [ADDR_W-1:0]        inst2_addr_o,
  output logic [DATA_W-1:0]        inst2_o,
  output logic                     inst2_is_pred_branch_o,
  input  logic                     pop1_i,
  input  logic                     pop2_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_inst [DEPTH];
  logic [DEPTH-1:0]  r_pred;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_ready;
  logic              w_inst1_valid;
  logic              w_inst2_valid;
  logic [1:0]        w_n_push;
  logic [1:0]        w_n_pop;
  logic [PTR_W-1:0]  w_head_p1;
  logic [PTR_W-1:0]  w_tail_p1;

  // Readiness is judged from the registered count only, so a full queue stays
  // not-ready for the cycle even if the consumer is popping at the same time.
  assign w_ready       = (r_count <= READY_MAX);
  assign w_inst1_valid = (r_count != '0);
  assign w_inst2_valid = (r_count >= CNT_W'(2));
  assign w_head_p1     = r_head + PTR_W'(1);
  assign w_tail_p1     = r_tail + PTR_W'(1);

  assign fetch_ready_o = w_ready;
  assign inst1_valid_o = w_inst1_valid;
  assign inst2_valid_o = w_inst2_valid;
  assign count_o       = r_count;

  // Number of entries accepted this cycle; a lone slot-2 push is never taken.
  always_comb begin
    w_n_push = 2'd0;
    if (w_ready && !jump_flag_i && push1_valid_i) begin
      w_n_push = push2_valid_i ? 2'd2 : 2'd1;
    end
  end

  // Number of entries consumed this cycle; pops on absent entries are ignored.
  always_comb begin
    w_n_pop = 2'd0;
    if (pop1_i && w_inst1_valid) begin
      w_n_pop = (pop2_i && w_inst2_valid) ? 2'd2 : 2'd1;
    end
  end

  // Pointer and occupancy bookkeeping; a flush overrides any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (jump_flag_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_n_pop);
      r_tail  <= r_tail + PTR_W'(w_n_push);
      r_count <= r_count + CNT_W'(w_n_push) - CNT_W'(w_n_pop);
    end
  end

  // Entry storage: slot 1 lands at the tail, slot 2 right behind it.
  always_ff @(posedge clk) begin
    if (w_n_push != 2'd0) begin
      r_addr[r_tail] <= push1_addr_i;
      r_inst[r_tail] <= push1_inst_i;
      r_pred[r_tail] <= push1_is_pred_branch_i;
    end
    if (w_n_push == 2'd2) begin
      r_addr[w_tail_p1] <= push2_addr_i;
      r_inst[w_tail_p1] <= push2_inst_i;
      r_pred[w_tail_p1] <= push2_is_pred_branch_i;
    end
  end

  // Present the two oldest entries, forcing absent slots to zero.
  always_comb begin
    inst1_addr_o           = '0;
    inst1_o                = '0;
    inst1_is_pred_branch_o = 1'b0;
    inst2_addr_o           = '0;
    inst2_o                = '0;
    inst2_is_pred_branch_o = 1'b0;
    if (w_inst1_valid) begin
      inst1_addr_o           = r_addr[r_head];
      inst1_o                = r_inst[r_head];
      inst1_is_pred_branch_o = r_pred[r_head];
    end
    if (w_inst2_valid) begin
      inst2_addr_o           = r_addr[w_head_p1];
      inst2_o                = r_inst[w_head_p1];
      inst2_is_pred_branch_o = r_pred[w_head_p1];
    end
  end

endmodule

// File: tb/tb_dual_inst_queue.sv
// tb_dual_inst_queue: scoreboard bench for dual_inst_queue. The driver pushes
// every accepted entry into an expected-order queue; a monitor compares the
// DUT outputs against that queue each cycle and retires consumed entries.
module tb_dual_inst_queue;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] inst;
    logic              pred;
  } entry_t;

  logic              clk;
  logic              rst_n;
  logic              jump_flag_i;
  logic              push1_valid_i;
  logic [ADDR_W-1:0] push1_addr_i;
  logic [DATA_W-1:0] push1_inst_i;
  logic              push1_is_pred_branch_i;
  logic              push2_valid_i;
  logic [ADDR_W-1:0] push2_addr_i;
  logic [DATA_W-1:0] push2_inst_i;
  logic              push2_is_pred_branch_i;
  logic              fetch_ready_o;
  logic              inst1_valid_o;
  logic [ADDR_W-1:0] inst1_addr_o;
  logic [DATA_W-1:0] inst1_o;
  logic              inst1_is_pred_branch_o;
  logic              inst2_valid_o;
  logic [ADDR_W-1:0] inst2_addr_o;
  logic [DATA_W-1:0] inst2_o;
  logic              inst2_is_pred_branch_o;
  logic              pop1_i;
  logic              pop2_i;
  logic [$clog2(DEPTH):0] count_o;

  entry_t            sbQ[$];
  logic [ADDR_W-1:0] nextAddr;
  int                checks;
  int                errors;

  dual_inst_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .jump_flag_i            (jump_flag_i),
    .push1_valid_i          (push1_valid_i),
    .push1_addr_i           (push1_addr_i),
    .push1_inst_i           (push1_inst_i),
    .push1_is_pred_branch_i (push1_is_pred_branch_i),
    .push2_valid_i          (push2_valid_i),
    .push2_addr_i           (push2_addr_i),
    .push2_inst_i           (push2_inst_i),
    .push2_is_pred_branch_i (push2_is_pred_branch_i),
    .fetch_ready_o          (fetch_ready_o),
    .inst1_valid_o          (inst1_valid_o),
    .inst1_addr_o           (inst1_addr_o),
    .inst1_o                (inst1_o),
    .inst1_is_pred_branch_o (inst1_is_pred_branch_o),
    .inst2_valid_o          (inst2_valid_o),
    .inst2_addr_o           (inst2_addr_o),
    .inst2_o                (inst2_o),
    .inst2_is_pred_branch_o (inst2_is_pred_branch_o),
    .pop1_i                 (pop1_i),
    .pop2_i                 (pop2_i),
    .count_o                (count_o)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
    end
  endtask

  // One cycle of stimulus: inputs change just after the falling edge, and the
  // entries the queue should accept are recorded just after the rising edge.
  task automatic applyStimulus(input bit v1, input bit v2, input bit p1, input bit p2, input bit j);
    entry_t a;
    entry_t b;
    int     nAcc;
    @(negedge clk);
    #1;
    a.addr = nextAddr;
    a.inst = $urandom;
    a.pred = 1'($urandom_range(0, 1));
    b.addr = nextAddr + 32'd4;
    b.inst = $urandom;
    b.pred = 1'($urandom_range(0, 1));
    push1_valid_i          = v1;
    push1_addr_i           = a.addr;
    push1_inst_i           = a.inst;
    push1_is_pred_branch_i = a.pred;
    push2_valid_i          = v2;
    push2_addr_i           = b.addr;
    push2_inst_i           = b.inst;
    push2_is_pred_branch_i = b.pred;
    pop1_i                 = p1;
    pop2_i                 = p2;
    jump_flag_i            = j;
    nAcc = 0;
    if (!j && v1 && (DEPTH - sbQ.size() >= 2)) nAcc = v2 ? 2 : 1;
    @(posedge clk);
    #1;
    if (nAcc >= 1) sbQ.push_back(a);
    if (nAcc == 2) sbQ.push_back(b);
    nextAddr = nextAddr + 32'(4 * nAcc);
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any clock edge.
  task automatic resetMid();
    @(negedge clk);
    #1;
    push1_valid_i = 1'b0;
    push2_valid_i = 1'b0;
    pop1_i        = 1'b0;
    pop2_i        = 1'b0;
    jump_flag_i   = 1'b0;
    #1;
    rst_n = 1'b0;
    sbQ.delete();
    #1;
    checkOutput("async_reset_count", 64'(count_o), 64'd0);
    checkOutput("async_reset_valid1", 64'(inst1_valid_o), 64'd0);
    checkOutput("async_reset_ready", 64'(fetch_ready_o), 64'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: just before each rising edge, compare outputs with the oldest
  // expected entries, then retire whatever this cycle consumes or flushes.
  always begin : monitorBlk
    int     n;
    entry_t e1;
    entry_t e2;
    @(negedge clk);
    #4;
    n = sbQ.size();
    e1 = '{addr: '0, inst: '0, pred: 1'b0};
    e2 = '{addr: '0, inst: '0, pred: 1'b0};
    if (n >= 1) e1 = sbQ[0];
    if (n >= 2) e2 = sbQ[1];
    checkOutput("count", 64'(count_o), 64'(n));
    checkOutput("fetch_ready", 64'(fetch_ready_o), 64'(DEPTH - n >= 2));
    checkOutput("inst1_valid", 64'(inst1_valid_o), 64'(n >= 1));
    checkOutput("inst2_valid", 64'(inst2_valid_o), 64'(n >= 2));
    checkOutput("inst1_addr", 64'(inst1_addr_o), 64'(e1.addr));
    checkOutput("inst1_word", 64'(inst1_o), 64'(e1.inst));
    checkOutput("inst1_pred", 64'(inst1_is_pred_branch_o), 64'(e1.pred));
    checkOutput("inst2_addr", 64'(inst2_addr_o), 64'(e2.addr));
    checkOutput("inst2_word", 64'(inst2_o), 64'(e2.inst));
    checkOutput("inst2_pred", 64'(inst2_is_pred_branch_o), 64'(e2.pred));
    if (rst_n && jump_flag_i) begin
      sbQ.delete();
    end else if (rst_n && pop1_i && n >= 1) begin
      void'(sbQ.pop_front());
      if (pop2_i && n >= 2) void'(sbQ.pop_front());
    end
  end

  initial begin
    int popPct;
    checks                 = 0;
    errors                 = 0;
    nextAddr               = 32'h100;
    rst_n                  = 1'b0;
    jump_flag_i            = 1'b0;
    push1_valid_i          = 1'b0;
    push1_addr_i           = '0;
    push1_inst_i           = '0;
    push1_is_pred_branch_i = 1'b0;
    push2_valid_i          = 1'b0;
    push2_addr_i           = '0;
    push2_inst_i           = '0;
    push2_is_pred_branch_i = 1'b0;
    pop1_i                 = 1'b0;
    pop2_i                 = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Idle after reset.
    repeat (2) applyStimulus(0, 0, 0, 0, 0);

    // Fill with pairs and no pops; once not ready, further pushes are dropped.
    repeat (6) applyStimulus(1, 1, 0, 0, 0);

    // Down to 6, then push 2 + pop 2 together keeps the count at 6.
    applyStimulus(0, 0, 1, 1, 0);
    repeat (2) applyStimulus(1, 1, 1, 1, 0);

    // Drain fully, including pops on an empty queue.
    repeat (5) applyStimulus(0, 0, 1, 1, 0);

    // One entry with a double pop, then a lone slot-2 push that must be ignored.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0);

    // Reach 5 entries, flush with a concurrent pair push, then refill.
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 1);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0);

    // Randomized traffic in phases of differing drain pressure, many wraps.
    for (int i = 0; i < 400; i++) begin
      case (i / 100)
        0:       popPct = 25;
        1:       popPct = 60;
        2:       popPct = 85;
        default: popPct = 50;
      endcase
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                    $urandom_range(0, 99) < popPct, $urandom_range(0, 1) != 0,
                    $urandom_range(0, 39) == 0);
      if (i == 250) begin
        repeat (3) applyStimulus(1, 1, 0, 0, 0);
        resetMid();
      end
    end

    // Drain what remains, then report.
    repeat (6) applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    #6;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
